// File: rtl/counter_controller_if.sv
// Strobe/direction bundle from the sequencing controller to the base-N counter core.
interface counter_controller_if;
  logic cnt_en;
  logic cnt_up;
  logic cnt_clr;

  modport master (output cnt_en, output cnt_up, output cnt_clr);
  modport slave  (input  cnt_en, input  cnt_up, input  cnt_clr);
endinterface

// File: rtl/counter_controller.sv
// Sequencing controller: synchronizes and debounces board inputs and turns them into
// single-cycle step/clear strobes plus a direction level for the counter core.
module counter_controller #(
  parameter int P_PUSHBUTTON_PERIOD = 2**16,
  parameter int P_TICK_PERIOD       = 50_000_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        btn_n,
  input  logic                        sw_mode,
  input  logic                        sw_dir,
  input  logic                        sw_clr,
  output logic                        run,
  output logic                        btn_lvl,
  counter_controller_if.master        cnt_bus
);

  localparam int DB_W = $clog2(P_PUSHBUTTON_PERIOD + 1);
  localparam int PS_W = $clog2(P_TICK_PERIOD + 1);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(P_PUSHBUTTON_PERIOD);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(P_TICK_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_MANUAL    = 2'd0,
    ST_AUTO_STOP = 2'd1,
    ST_AUTO_RUN  = 2'd2
  } state_t;

  logic [1:0]      btn_sync_r, mode_sync_r, dir_sync_r, clr_sync_r;
  logic            clr_prev_r;
  logic [DB_W-1:0] db_cnt_r;
  logic [PS_W-1:0] ps_cnt_r;
  logic            btn_lvl_r, press_r, tick_r, clr_evt_r;
  logic            cnt_en_r, cnt_up_r, cnt_clr_r, run_r;
  state_t          state_r, state_next_s;
  logic            db_differ_s, db_flip_s, wrap_s, clr_rise_s, man_step_s;

  // Two-flop synchronizers; the button idles released (high), everything else low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync_r  <= 2'b11;
      mode_sync_r <= 2'b00;
      dir_sync_r  <= 2'b00;
      clr_sync_r  <= 2'b00;
      clr_prev_r  <= 1'b0;
    end else begin
      btn_sync_r  <= {btn_sync_r[0], btn_n};
      mode_sync_r <= {mode_sync_r[0], sw_mode};
      dir_sync_r  <= {dir_sync_r[0], sw_dir};
      clr_sync_r  <= {clr_sync_r[0], sw_clr};
      clr_prev_r  <= clr_sync_r[1];
    end
  end

  // Raw level is active-low, so equality with the pressed flag means disagreement.
  assign db_differ_s = (btn_sync_r[1] == btn_lvl_r);
  assign db_flip_s   = db_differ_s && (db_cnt_r == DB_MAX);

  // Debounce counter, debounced level and the registered press event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_r  <= {DB_W{1'b0}};
      btn_lvl_r <= 1'b0;
      press_r   <= 1'b0;
    end else begin
      if (!db_differ_s || db_flip_s) begin
        db_cnt_r <= {DB_W{1'b0}};
      end else begin
        db_cnt_r <= db_cnt_r + DB_W'(1);
      end
      btn_lvl_r <= db_flip_s ? ~btn_lvl_r : btn_lvl_r;
      press_r   <= db_flip_s && !btn_lvl_r;
    end
  end

  // Next-state logic and step/clear event decode; mode switch outranks a press.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_MANUAL: begin
        if (mode_sync_r[1]) state_next_s = ST_AUTO_STOP;
        else                state_next_s = ST_MANUAL;
      end
      ST_AUTO_STOP: begin
        if (!mode_sync_r[1]) state_next_s = ST_MANUAL;
        else if (press_r)    state_next_s = ST_AUTO_RUN;
        else                 state_next_s = ST_AUTO_STOP;
      end
      ST_AUTO_RUN: begin
        if (!mode_sync_r[1]) state_next_s = ST_MANUAL;
        else if (press_r)    state_next_s = ST_AUTO_STOP;
        else                 state_next_s = ST_AUTO_RUN;
      end
      default: state_next_s = ST_MANUAL;
    endcase
  end

  assign wrap_s     = (state_r == ST_AUTO_RUN) && (ps_cnt_r == PS_LAST);
  assign clr_rise_s = clr_sync_r[1] && !clr_prev_r;
  assign man_step_s = (state_r == ST_MANUAL) && press_r && !mode_sync_r[1];

  // State register, prescaler and internal tick/clear events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_MANUAL;
      ps_cnt_r  <= {PS_W{1'b0}};
      tick_r    <= 1'b0;
      clr_evt_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if ((state_r != ST_AUTO_RUN) || clr_rise_s || wrap_s) begin
        ps_cnt_r <= {PS_W{1'b0}};
      end else begin
        ps_cnt_r <= ps_cnt_r + PS_W'(1);
      end
      tick_r    <= wrap_s && (state_next_s == ST_AUTO_RUN);
      clr_evt_r <= clr_rise_s;
    end
  end

  // Registered outputs; a clear in the same cycle swallows the step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_en_r  <= 1'b0;
      cnt_clr_r <= 1'b0;
      cnt_up_r  <= 1'b1;
      run_r     <= 1'b0;
    end else begin
      cnt_en_r  <= (man_step_s || tick_r) && !clr_evt_r;
      cnt_clr_r <= clr_evt_r;
      cnt_up_r  <= ~dir_sync_r[1];
      run_r     <= (state_next_s == ST_AUTO_RUN);
    end
  end

  assign cnt_bus.cnt_en  = cnt_en_r;
  assign cnt_bus.cnt_clr = cnt_clr_r;
  assign cnt_bus.cnt_up  = cnt_up_r;
  assign run             = run_r;
  assign btn_lvl         = btn_lvl_r;

endmodule

// File: tb/tb_counter_controller.sv
// Directed self-checking bench for counter_controller with short debounce/tick periods.
module tb_counter_controller;

  logic clk = 1'b0;
  logic rst_n, btn_n, sw_mode, sw_dir, sw_clr;
  logic run, btn_lvl;

  counter_controller_if bus ();

  counter_controller #(
    .P_PUSHBUTTON_PERIOD (16),
    .P_TICK_PERIOD       (10)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n   (btn_n),
    .sw_mode (sw_mode),
    .sw_dir  (sw_dir),
    .sw_clr  (sw_clr),
    .run     (run),
    .btn_lvl (btn_lvl),
    .cnt_bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Strobe monitor: pulse counts, timestamps, width and overlap tracking.
  int en_cnt = 0, clr_cnt = 0, clr_t = -1, run_rise = -1, run_fall = -1;
  int wide = 0, overlap = 0;
  int en_t[$];
  logic en_prev = 1'b0, clr_prev = 1'b0, run_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (bus.cnt_en === 1'b1) begin
      en_cnt++;
      en_t.push_back(cyc);
      if (en_prev) wide++;
    end
    if (bus.cnt_clr === 1'b1) begin
      clr_cnt++;
      clr_t = cyc;
      if (clr_prev) wide++;
    end
    if (bus.cnt_en === 1'b1 && bus.cnt_clr === 1'b1) overlap++;
    if (run === 1'b1 && !run_prev) run_rise = cyc;
    if (run !== 1'b1 && run_prev)  run_fall = cyc;
    en_prev  = (bus.cnt_en === 1'b1);
    clr_prev = (bus.cnt_clr === 1'b1);
    run_prev = (run === 1'b1);
  end

  int base, cbase, t0, r0, tp;

  initial begin
    rst_n = 1'b0; btn_n = 1'b1; sw_mode = 1'b0; sw_dir = 1'b0; sw_clr = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_en",  bus.cnt_en,  0);
    check("rst_clr", bus.cnt_clr, 0);
    check("rst_run", run,         0);
    check("rst_lvl", btn_lvl,     0);
    check("rst_up",  bus.cnt_up,  1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_run", run, 0);
    check("post_rst_up",  bus.cnt_up, 1);

    // Bouncing button: never stable long enough, then a clean 20-cycle low.
    base = en_cnt;
    for (int i = 0; i < 12; i++) begin
      btn_n = ~btn_n;
      repeat (5) @(negedge clk);
    end
    check("bounce_none", en_cnt - base, 0);
    btn_n = 1'b0;
    t0 = cyc;
    repeat (20) @(negedge clk);
    check("bounce_one", en_cnt - base, 1);
    check("bounce_time", en_t[$], t0 + 20);
    check("bounce_lvl", btn_lvl, 1);
    btn_n = 1'b1;
    repeat (30) @(negedge clk);
    check("bounce_release", en_cnt - base, 1);
    check("release_lvl", btn_lvl, 0);

    // Manual steps counting down.
    sw_dir = 1'b1;
    repeat (5) @(negedge clk);
    check("dir_down", bus.cnt_up, 0);
    base = en_cnt;
    for (int p = 0; p < 3; p++) begin
      btn_n = 1'b0;
      tp = cyc;
      repeat (40) @(negedge clk);
      check("man_time", en_t[$], tp + 20);
      check("man_up", bus.cnt_up, 0);
      btn_n = 1'b1;
      repeat (40) @(negedge clk);
    end
    check("man_count", en_cnt - base, 3);
    sw_dir = 1'b0;

    // Auto mode: start, five ticks, stop.
    sw_mode = 1'b1;
    repeat (6) @(negedge clk);
    check("auto_stop_run", run, 0);
    base = en_cnt;
    btn_n = 1'b0; t0 = cyc;
    repeat (30) @(negedge clk);
    btn_n = 1'b1;
    repeat (25) @(negedge clk);
    btn_n = 1'b0;
    repeat (30) @(negedge clk);
    btn_n = 1'b1;
    repeat (40) @(negedge clk);
    r0 = t0 + 20;
    check("auto_rise", run_rise, r0);
    check("auto_fall", run_fall, t0 + 75);
    check("auto_count", en_cnt - base, 5);
    for (int i = 0; i < 5; i++) check("auto_tick", en_t[base + i], r0 + 11 + 10 * i);
    check("auto_run_end", run, 0);

    // Clear landing on a prescaler wrap.
    base = en_cnt; cbase = clr_cnt;
    btn_n = 1'b0; t0 = cyc;
    repeat (30) @(negedge clk);
    btn_n = 1'b1;
    repeat (17) @(negedge clk);
    sw_clr = 1'b1;
    repeat (20) @(negedge clk);
    sw_clr = 1'b0;
    r0 = t0 + 20;
    check("clr_rise_run", run_rise, r0);
    check("clr_count", clr_cnt - cbase, 1);
    check("clr_time", clr_t, r0 + 31);
    check("clr_en_count", en_cnt - base, 3);
    check("clr_en0", en_t[base],     r0 + 11);
    check("clr_en1", en_t[base + 1], r0 + 21);
    check("clr_en2", en_t[base + 2], clr_t + 10);
    check("clr_run", run, 1);

    // Reset in the middle of an interval.
    while (cyc < r0 + 57) @(negedge clk);
    check("pre_rst_run", run, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_run", run, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = en_cnt;
    repeat (30) @(negedge clk);
    check("rst_mid_en", en_cnt - base, 0);
    check("rst_mid_run", run, 0);

    check("strobe_wide", wide, 0);
    check("strobe_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
